// File: rtl/pong_engine.sv
// pong_engine: per-frame pong physics -- paddles, ball, scoring, the
// serve/point/over state machine and beep timing, all advanced on frame_tick.
module pong_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int PAD_H       = 50,
    parameter int PAD_W       = 8,
    parameter int BALL_SZ     = 8,
    parameter int P1_X        = 40,
    parameter int P2_X        = 600,
    parameter int P_SPD       = 4,
    parameter int B_SPD       = 3,
    parameter int WIN_SCORE   = 9,
    parameter int SCORE_W     = 4,
    parameter int POINT_DELAY = 60,
    parameter int BEEP_FRAMES = 6,
    localparam int XW = $clog2(SCREEN_W),
    localparam int YW = $clog2(SCREEN_H)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               p1_up,
    input  logic               p1_dn,
    input  logic               p1_srv,
    input  logic               p2_up,
    input  logic               p2_dn,
    input  logic               p2_srv,
    output logic [YW-1:0]      p1_y,
    output logic [YW-1:0]      p2_y,
    output logic [XW-1:0]      ball_x,
    output logic [YW-1:0]      ball_y,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         state,
    output logic               server,
    output logic               beep_low,
    output logic               beep_high
);
    localparam int PAD_MAX = SCREEN_H - PAD_H;
    localparam int BY_MAX  = SCREEN_H - BALL_SZ;
    localparam int BX_MAX  = SCREEN_W - BALL_SZ;
    localparam int P1_FACE = P1_X + PAD_W;
    localparam int P2_FACE = P2_X - BALL_SZ;
    localparam int PCW     = $clog2(POINT_DELAY);
    localparam int BW      = $clog2(BEEP_FRAMES + 1);
    localparam logic [YW-1:0]      Y_CTR     = YW'(PAD_MAX / 2);
    localparam logic [YW-1:0]      B_OFS     = YW'((PAD_H - BALL_SZ) / 2);
    localparam logic [YW-1:0]      PAD_MAX_Y = YW'(PAD_MAX);
    localparam logic signed [YW:0] PS        = (YW+1)'(P_SPD);
    localparam logic [PCW-1:0]     PC_LAST   = PCW'(POINT_DELAY - 1);
    localparam logic [BW-1:0]      BEEP_LD   = BW'(BEEP_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_S     = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {SERVE = 2'b00, PLAY = 2'b01, POINT = 2'b10, OVER = 2'b11} state_t;

    state_t             st, st_nx;
    logic [YW-1:0]      p1_nx, p2_nx, by_nx;
    logic [XW-1:0]      bx_nx;
    logic               dx_neg, dy_neg, dx_nx, dy_nx, server_nx;
    logic [SCORE_W-1:0] s1_nx, s2_nx;
    logic [PCW-1:0]     pcnt, pcnt_nx;
    logic [BW-1:0]      bl_cnt, bh_cnt, bl_nx, bh_nx;
    logic [1:0]         srv_q, rise, pend, pend_nx;
    logic               ev_lo, ev_hi, hit1, hit2;
    int                 nx, ny;

    assign rise      = {p2_srv, p1_srv} & ~srv_q;
    assign state     = st;
    assign beep_low  = |bl_cnt;
    assign beep_high = |bh_cnt;

    // Signed, one bit wider than y so an upward step past 0 clamps instead of wrapping.
    function automatic logic [YW-1:0] pad_move(input logic [YW-1:0] y, input logic up, input logic dn);
        logic signed [YW:0] t;
        t = $signed({1'b0, y});
        if (up && !dn) t = t - PS;
        else if (dn && !up) t = t + PS;
        return int'(t) < 0 ? '0 : int'(t) > PAD_MAX ? PAD_MAX_Y : t[YW-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= SERVE;
            server <= 1'b1;
            score1 <= '0;
            score2 <= '0;
            p1_y   <= Y_CTR;
            p2_y   <= Y_CTR;
            ball_x <= XW'(P2_FACE);
            ball_y <= Y_CTR + B_OFS;
            dx_neg <= 1'b1;
            dy_neg <= 1'b0;
            pcnt   <= '0;
            bl_cnt <= '0;
            bh_cnt <= '0;
            srv_q  <= '0;
            pend   <= '0;
        end else begin
            st     <= st_nx;
            server <= server_nx;
            score1 <= s1_nx;
            score2 <= s2_nx;
            p1_y   <= p1_nx;
            p2_y   <= p2_nx;
            ball_x <= bx_nx;
            ball_y <= by_nx;
            dx_neg <= dx_nx;
            dy_neg <= dy_nx;
            pcnt   <= pcnt_nx;
            bl_cnt <= bl_nx;
            bh_cnt <= bh_nx;
            srv_q  <= {p2_srv, p1_srv};
            pend   <= pend_nx;
        end
    end

    always_comb begin
        st_nx     = st;
        server_nx = server;
        s1_nx     = score1;
        s2_nx     = score2;
        p1_nx     = p1_y;
        p2_nx     = p2_y;
        bx_nx     = ball_x;
        by_nx     = ball_y;
        dx_nx     = dx_neg;
        dy_nx     = dy_neg;
        pcnt_nx   = pcnt;
        bl_nx     = bl_cnt;
        bh_nx     = bh_cnt;
        pend_nx   = pend | rise;
        ev_lo     = 1'b0;
        ev_hi     = 1'b0;
        nx = int'(ball_x) + (dx_neg ? -B_SPD : B_SPD);
        ny = int'(ball_y) + (dy_neg ? -B_SPD : B_SPD);
        hit1 = dx_neg && int'(ball_x) >= P1_FACE && nx <= P1_FACE &&
               int'(ball_y) + BALL_SZ > int'(p1_y) && int'(ball_y) < int'(p1_y) + PAD_H;
        hit2 = !dx_neg && int'(ball_x) + BALL_SZ <= P2_X && nx + BALL_SZ >= P2_X &&
               int'(ball_y) + BALL_SZ > int'(p2_y) && int'(ball_y) < int'(p2_y) + PAD_H;
        // While serving, the ball rides the server's paddle every clock.
        if (st == SERVE) begin
            bx_nx = server ? XW'(P2_FACE) : XW'(P1_FACE);
            by_nx = (server ? p2_y : p1_y) + B_OFS;
        end
        if (frame_tick) begin
            pend_nx = rise;
            bl_nx   = bl_cnt != '0 ? bl_cnt - 1'b1 : '0;
            bh_nx   = bh_cnt != '0 ? bh_cnt - 1'b1 : '0;
            if (st != OVER) begin
                p1_nx = pad_move(p1_y, p1_up, p1_dn);
                p2_nx = pad_move(p2_y, p2_up, p2_dn);
            end
            case (st)
                SERVE: if (pend[server]) begin
                    st_nx = PLAY;
                    dx_nx = server;
                    dy_nx = 1'b0;
                end
                PLAY: begin
                    if (ny <= 0) begin
                        by_nx = '0;
                        dy_nx = 1'b0;
                        ev_lo = 1'b1;
                    end else if (ny >= BY_MAX) begin
                        by_nx = YW'(BY_MAX);
                        dy_nx = 1'b1;
                        ev_lo = 1'b1;
                    end else begin
                        by_nx = YW'(ny);
                    end
                    if (hit1) begin
                        bx_nx = XW'(P1_FACE);
                        dx_nx = 1'b0;
                        ev_lo = 1'b1;
                    end else if (hit2) begin
                        bx_nx = XW'(P2_FACE);
                        dx_nx = 1'b1;
                        ev_lo = 1'b1;
                    end else if (nx <= 0 || nx >= BX_MAX) begin
                        bx_nx     = nx <= 0 ? '0 : XW'(BX_MAX);
                        s1_nx     = nx > 0 && score1 != WIN_S ? score1 + 1'b1 : score1;
                        s2_nx     = nx <= 0 && score2 != WIN_S ? score2 + 1'b1 : score2;
                        server_nx = nx > 0;
                        st_nx     = POINT;
                        pcnt_nx   = '0;
                        ev_hi     = 1'b1;
                    end else begin
                        bx_nx = XW'(nx);
                    end
                end
                POINT: if (pcnt == PC_LAST) st_nx = (score1 == WIN_S || score2 == WIN_S) ? OVER : SERVE;
                       else pcnt_nx = pcnt + 1'b1;
                OVER: if (|pend) begin
                    st_nx = SERVE;
                    s1_nx = '0;
                    s2_nx = '0;
                    p1_nx = Y_CTR;
                    p2_nx = Y_CTR;
                end
            endcase
            if (ev_lo) bl_nx = BEEP_LD;
            if (ev_hi) bh_nx = BEEP_LD;
        end
    end
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: directed stimulus against a frame-level behavioural model of
// the pong rules, checked after every frame, plus hand-computed anchor values.
module tb_pong_engine;
    localparam int SW = 640, SH = 480, PH = 50, BSZ = 8;
    localparam int P1F = 48, P2X = 600, PSPD = 4, BSPD = 3, WIN = 9;

    logic       clk = 0, rst_n = 0, frame_tick = 0;
    logic       p1_up = 0, p1_dn = 0, p1_srv = 0, p2_up = 0, p2_dn = 0, p2_srv = 0;
    logic [8:0] p1_y, p2_y, ball_y;
    logic [9:0] ball_x;
    logic [3:0] score1, score2;
    logic [1:0] state;
    logic       server, beep_low, beep_high;

    int n_tests = 0, n_fail = 0;
    int m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2, m_st, m_srv, m_pc, m_bl, m_bh, m_h2;
    bit m_pend[2];

    pong_engine dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .p1_up(p1_up), .p1_dn(p1_dn), .p1_srv(p1_srv),
        .p2_up(p2_up), .p2_dn(p2_dn), .p2_srv(p2_srv),
        .p1_y(p1_y), .p2_y(p2_y), .ball_x(ball_x), .ball_y(ball_y),
        .score1(score1), .score2(score2), .state(state), .server(server),
        .beep_low(beep_low), .beep_high(beep_high)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_p1 = (SH - PH) / 2; m_p2 = m_p1;
        m_bx = P2X - BSZ; m_by = m_p2 + (PH - BSZ) / 2;
        m_dx = -1; m_dy = 1; m_s1 = 0; m_s2 = 0; m_st = 0; m_srv = 1;
        m_pc = 0; m_bl = 0; m_bh = 0; m_h2 = 0; m_pend[0] = 0; m_pend[1] = 0;
    endtask

    function automatic int pmove(input int y, input bit up, input bit dn);
        int t = y + ((up && !dn) ? -PSPD : 0) + ((dn && !up) ? PSPD : 0);
        return t < 0 ? 0 : (t > SH - PH ? SH - PH : t);
    endfunction

    function automatic int exp_bx();
        return m_st == 0 ? (m_srv ? P2X - BSZ : P1F) : m_bx;
    endfunction

    function automatic int exp_by();
        return m_st == 0 ? (m_srv ? m_p2 : m_p1) + (PH - BSZ) / 2 : m_by;
    endfunction

    // One frame of the game rules, using the controls that were held over the tick.
    task automatic model_tick();
        int nx, ny, op1, op2;
        bit lo, hi, h1, h2;
        op1 = m_p1; op2 = m_p2; lo = 0; hi = 0;
        if (m_st != 3) begin
            m_p1 = pmove(m_p1, p1_up, p1_dn);
            m_p2 = pmove(m_p2, p2_up, p2_dn);
        end
        if (m_st == 0) begin
            if (m_pend[m_srv]) begin
                m_bx = m_srv ? P2X - BSZ : P1F;
                m_by = (m_srv ? op2 : op1) + (PH - BSZ) / 2;
                m_dx = m_srv ? -1 : 1; m_dy = 1; m_st = 1;
            end
        end else if (m_st == 1) begin
            nx = m_bx + BSPD * m_dx; ny = m_by + BSPD * m_dy;
            h1 = m_dx < 0 && m_bx >= P1F && nx <= P1F && m_by + BSZ > op1 && m_by < op1 + PH;
            h2 = m_dx > 0 && m_bx + BSZ <= P2X && nx + BSZ >= P2X && m_by + BSZ > op2 && m_by < op2 + PH;
            if (ny <= 0) begin m_by = 0; m_dy = 1; lo = 1; end
            else if (ny >= SH - BSZ) begin m_by = SH - BSZ; m_dy = -1; lo = 1; end
            else m_by = ny;
            if (h1) begin m_bx = P1F; m_dx = 1; lo = 1; end
            else if (h2) begin m_bx = P2X - BSZ; m_dx = -1; lo = 1; m_h2++; end
            else if (nx <= 0) begin
                m_bx = 0; m_s2 = m_s2 < WIN ? m_s2 + 1 : WIN; m_srv = 0; m_st = 2; m_pc = 0; hi = 1;
            end else if (nx >= SW - BSZ) begin
                m_bx = SW - BSZ; m_s1 = m_s1 < WIN ? m_s1 + 1 : WIN; m_srv = 1; m_st = 2; m_pc = 0; hi = 1;
            end else m_bx = nx;
        end else if (m_st == 2) begin
            m_pc++;
            if (m_pc == 60) m_st = (m_s1 == WIN || m_s2 == WIN) ? 3 : 0;
        end else if (m_pend[0] || m_pend[1]) begin
            m_st = 0; m_s1 = 0; m_s2 = 0; m_p1 = (SH - PH) / 2; m_p2 = m_p1;
        end
        m_bl = lo ? 6 : (m_bl > 0 ? m_bl - 1 : 0);
        m_bh = hi ? 6 : (m_bh > 0 ? m_bh - 1 : 0);
        m_pend[0] = 0; m_pend[1] = 0;
    endtask

    task automatic check_model();
        chk("p1_y", p1_y, m_p1);
        chk("p2_y", p2_y, m_p2);
        chk("ball_x", ball_x, exp_bx());
        chk("ball_y", ball_y, exp_by());
        chk("score1", score1, m_s1);
        chk("score2", score2, m_s2);
        chk("state", state, m_st);
        chk("server", server, m_srv);
        chk("beep_low", beep_low, m_bl > 0);
        chk("beep_high", beep_high, m_bh > 0);
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1;
        @(negedge clk) frame_tick = 0;
        model_tick();
        repeat (2) @(negedge clk);
        check_model();
    endtask

    task automatic press(input int p);
        @(negedge clk);
        if (p == 0) p1_srv = 1; else p2_srv = 1;
        @(negedge clk);
        p1_srv = 0; p2_srv = 0;
        @(negedge clk);
        m_pend[p] = 1;
    endtask

    // Steer a paddle toward the ball (track) or away from it.
    task automatic pilot(input bit t1, input bit t2);
        int bc = exp_by() + BSZ / 2;
        int c1 = m_p1 + PH / 2, c2 = m_p2 + PH / 2;
        p1_up = t1 ? c1 > bc + 2 : c1 <= bc;
        p1_dn = t1 ? c1 < bc - 2 : c1 > bc;
        p2_up = t2 ? c2 > bc + 2 : c2 <= bc;
        p2_dn = t2 ? c2 < bc - 2 : c2 > bc;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_p1_y"}, p1_y, 215);
        chk({tag, "_p2_y"}, p2_y, 215);
        chk({tag, "_ball_x"}, ball_x, 592);
        chk({tag, "_ball_y"}, ball_y, 236);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_server"}, server, 1);
        chk({tag, "_scores"}, score1 + score2, 0);
        chk({tag, "_beeps"}, beep_low + beep_high, 0);
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_held");
        rst_n = 1;
        @(negedge clk);
        chk_reset_vals("rst_released");
        check_model();

        p1_up = 1;
        tick();
        chk("lit_p1_first_up", p1_y, 211);
        repeat (59) tick();
        chk("lit_p1_clamped", p1_y, 0);
        p1_dn = 1;
        tick();
        chk("lit_p1_both", p1_y, 0);
        p1_up = 0; p1_dn = 0;

        press(0);
        tick();
        chk("lit_nonserver_ignored", state, 0);
        press(1);
        tick();
        chk("lit_served", state, 1);
        chk("lit_serve_x", ball_x, 592);
        tick();
        chk("lit_first_move_x", ball_x, 589);
        chk("lit_first_move_y", ball_y, 239);
        for (int k = 2; k <= 198; k++) begin
            tick();
            if (k == 79) begin
                chk("lit_wall_y", ball_y, 472);
                chk("lit_wall_beep", beep_low, 1);
            end
            if (k == 84) chk("lit_beep_last", beep_low, 1);
            if (k == 85) chk("lit_beep_off", beep_low, 0);
        end
        chk("lit_goal_state", state, 2);
        chk("lit_goal_score2", score2, 1);
        chk("lit_goal_server", server, 0);
        chk("lit_goal_x", ball_x, 0);
        chk("lit_goal_y", ball_y, 115);
        chk("lit_goal_beep", beep_high, 1);
        repeat (59) tick();
        chk("lit_point_hold", state, 2);
        tick();
        chk("lit_point_done", state, 0);
        chk("lit_p1_serve_x", ball_x, 48);
        chk("lit_p1_serve_y", ball_y, 21);

        for (int f = 0; f < 6000 && m_st != 3; f++) begin
            pilot(1, 0);
            if (m_st == 0) press(m_srv);
            tick();
        end
        chk("game_over_reached", state, 3);
        p1_up = 1; p1_dn = 0; p2_up = 0; p2_dn = 1;
        tick();
        p1_up = 0; p2_dn = 0;
        press(0);
        tick();
        chk("lit_restart_state", state, 0);
        chk("lit_restart_scores", score1 + score2, 0);
        chk("lit_restart_server", server, 1);
        chk("lit_restart_p1", p1_y, 215);

        for (int f = 0; f < 3000 && m_st != 2; f++) begin
            pilot(m_h2 == 0, 1);
            if (m_st == 0) press(m_srv);
            tick();
        end
        chk("point_reached", state, 2);
        chk("p2_hit_seen", m_h2 > 0, 1);
        p1_up = 0; p1_dn = 0; p2_up = 0; p2_dn = 0;
        repeat (5) tick();
        #3 rst_n = 0;
        #1;
        m_reset();
        chk_reset_vals("mid_point_rst");
        p1_up = 1; frame_tick = 1;
        repeat (3) @(negedge clk);
        frame_tick = 0; p1_up = 0;
        chk_reset_vals("tick_in_rst");
        rst_n = 1;
        @(negedge clk);
        press(1);
        tick();
        tick();
        chk("lit_after_rst_x", ball_x, 589);
        chk("lit_after_rst_y", ball_y, 239);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
